// File: rtl/array_loader.sv
// array_loader: writable lookup table loaded from a valid/ready sample stream.
// Samples are written to auto-incrementing addresses. A registered read port
// (rd_addr -> rd_data) is available in every state.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   start     : begin or restart a load (ignored while a load is in progress)
//   in_data   : signed sample, qualified by in_valid and in_ready
//   load_done : one-cycle pulse in the first cycle after the last entry is written
//   loaded    : high while the table holds a complete load
//   wr_count  : number of entries written in the current or last load
//   rd_addr   : read address; rd_data returns mem[rd_addr] one cycle later (read-first)
// DATA_EXPONENT only describes the fixed-point scaling; the block applies no scaling.
module array_loader #(
    parameter int ADDR_WIDTH    = 2,
    parameter int DATA_WIDTH    = 25,
    parameter int DATA_EXPONENT = -16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         load_done,
    output logic                         loaded,
    output logic        [ADDR_WIDTH:0]   wr_count,
    input  logic        [ADDR_WIDTH-1:0] rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t                       state, state_n;
    logic        [ADDR_WIDTH-1:0] ptr;
    logic signed [DATA_WIDTH-1:0] mem [DEPTH];
    logic                         wr, last, restart;

    assign in_ready = state == LOAD;
    assign loaded   = state == FULL;
    assign wr       = in_ready && in_valid;
    assign last     = wr && ptr == ADDR_WIDTH'(DEPTH - 1);
    // start is honoured only outside LOAD, so a last write always wins
    assign restart  = start && state != LOAD;

    always_comb begin
        state_n = last ? FULL : restart ? LOAD : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            wr_count  <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= last;
            if (restart) begin
                ptr      <= '0;
                wr_count <= '0;
            end else if (wr) begin
                ptr      <= ptr + 1'b1;
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    // rd_data samples mem before this edge's write lands, giving read-first behaviour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rd_data <= mem[rd_addr];
            if (wr) mem[ptr] <= in_data;
        end
    end
endmodule

// File: tb/tb_array_loader.sv
// tb_array_loader: scoreboard bench for array_loader.
module tb_array_loader;
    localparam int AW    = 2;
    localparam int DW    = 25;
    localparam int DEPTH = 4;

    typedef enum int {M_IDLE, M_LOAD, M_FULL} mst_t;

    logic                 clk      = 1'b0;
    logic                 rst      = 1'b1;
    logic                 start    = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data  = '0;
    logic        [AW-1:0] rd_addr  = '0;
    logic                 in_ready, load_done, loaded;
    logic        [AW:0]   wr_count;
    logic signed [DW-1:0] rd_data;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    mst_t                 m_st;
    int                   m_ptr, m_cnt;
    logic                 m_done;
    logic signed [DW-1:0] m_mem [DEPTH];
    logic signed [DW-1:0] sb [$];
    logic signed [DW-1:0] basic [DEPTH] = '{25'sd10, -25'sd3, 25'sd7, 25'sd1000};
    logic signed [DW-1:0] second [DEPTH] = '{25'sd5, 25'sd6, 25'sd7, 25'sd8};

    array_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_EXPONENT(-16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .load_done(load_done), .loaded(loaded), .wr_count(wr_count),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    endtask

    task automatic model_reset();
        m_st   = M_IDLE;
        m_ptr  = 0;
        m_cnt  = 0;
        m_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        sb.delete();
    endtask

    // one clock: drive at negedge, predict, check #1 after the rising edge
    task automatic cycle(input logic s, input logic v, input logic signed [DW-1:0] d,
                         input logic [AW-1:0] a);
        logic w, l;
        start    = s;
        in_valid = v;
        in_data  = d;
        rd_addr  = a;
        sb.push_back(m_mem[a]);
        w = m_st == M_LOAD && v;
        l = w && m_ptr == DEPTH - 1;
        if (w) begin
            m_mem[m_ptr] = d;
            m_ptr++;
            m_cnt++;
        end
        m_done = l;
        if (l) m_st = M_FULL;
        else if (s && m_st != M_LOAD) begin
            m_st  = M_LOAD;
            m_ptr = 0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        check("rd_data", rd_data, sb.pop_front());
        check("in_ready", {31'b0, in_ready}, {31'b0, m_st == M_LOAD});
        check("loaded", {31'b0, loaded}, {31'b0, m_st == M_FULL});
        check("load_done", {31'b0, load_done}, {31'b0, m_done});
        check("wr_count", 32'(wr_count), m_cnt);
        if (load_done) n_done++;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_rd_data", rd_data, 0);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_loaded", {31'b0, loaded}, 0);
        check("rst_load_done", {31'b0, load_done}, 0);
        check("rst_wr_count", 32'(wr_count), 0);
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 1'b0, '0, AW'(a));
            check("rst_read", rd_data, 0);
        end

        n_done = 0;
        cycle(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, basic[i], '0);
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 1'b0, '0, AW'(a));
            check("basic_read", rd_data, basic[a]);
        end
        check("basic_count", 32'(wr_count), DEPTH);
        check("basic_done_once", n_done, 1);

        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 25'sd10, '0);
        repeat (3) cycle(1'b0, 1'b0, '0, '0);
        check("gap_count", 32'(wr_count), 1);
        cycle(1'b0, 1'b1, 25'sd42, 2'd1);
        check("collide_old", rd_data, -3);
        cycle(1'b0, 1'b0, '0, 2'd1);
        check("collide_new", rd_data, 42);
        repeat (3) cycle(1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, 25'sd7, '0);
        check("load_start_ignored", 32'(wr_count), 3);
        cycle(1'b1, 1'b1, 25'sd1000, '0);
        check("last_write_wins", {31'b0, loaded}, 1);
        cycle(1'b0, 1'b0, '0, '0);

        cycle(1'b1, 1'b0, '0, '0);
        check("restart_loaded", {31'b0, loaded}, 0);
        check("restart_count", 32'(wr_count), 0);
        cycle(1'b0, 1'b1, second[0], '0);
        cycle(1'b0, 1'b0, '0, '0);
        check("restart_addr0", rd_data, 5);
        cycle(1'b0, 1'b0, '0, 2'd1);
        check("restart_old1", rd_data, 42);
        cycle(1'b0, 1'b1, second[1], 2'd2);
        check("restart_old2", rd_data, 7);
        cycle(1'b0, 1'b1, second[2], 2'd3);
        check("restart_old3", rd_data, 1000);
        cycle(1'b0, 1'b1, second[3], '0);
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 1'b0, '0, AW'(a));
            check("restart_read", rd_data, second[a]);
        end

        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 25'sd11, '0);
        cycle(1'b0, 1'b1, 25'sd12, '0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'b0, in_ready}, 0);
        check("midrst_count", 32'(wr_count), 0);
        check("midrst_rd_data", rd_data, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 2; a++) begin
            cycle(1'b0, 1'b0, '0, AW'(a));
            check("midrst_read", rd_data, 0);
        end
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 25'sd99, '0);
        cycle(1'b0, 1'b0, '0, '0);
        check("midrst_reload", rd_data, 99);
        check("midrst_reload_count", 32'(wr_count), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/array_loader.md
# array_loader

Writable lookup table for fixed-point analog emulation: the write-side counterpart of the addressed real-valued `array` read path. A producer streams fixed-point samples over a valid/ready handshake. The block stores them at auto-incrementing addresses and exposes a registered read port (`rd_addr` → `rd_data`) that downstream analog models index with an address counter. It sits between a table source (host, ROM streamer, or calibration engine) and emulated models that consume per-address real values.

## Interface
Parameters:
- `ADDR_WIDTH`, 2: address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 25: signed fixed-point word width, shared by the input and stored data.
- `DATA_EXPONENT`, -16: fixed-point exponent of stored and read data. It is metadata for `PASS_REAL` consumers only; the block applies no scaling.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `start`  input  1  single-cycle request to begin (or restart) a table load.
- `in_data`  input  DATA_WIDTH  signed sample to write.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block accepts a sample this cycle.
- `load_done`  output  1  one-cycle pulse when the final entry is written.
- `loaded`  output  1  level; high while the table holds a complete load.
- `wr_count`  output  ADDR_WIDTH+1  entries written in the current or last load (0..DEPTH).
- `rd_addr`  input  ADDR_WIDTH  read address.
- `rd_data`  output  DATA_WIDTH  signed stored word at the registered `rd_addr`.

## Operation
- States: IDLE, LOAD, FULL.
- IDLE: `in_ready`=0, `loaded`=0. `start` → LOAD, with write pointer := 0 and `wr_count` := 0.
- LOAD:
  - `in_ready`=1.
  - On `in_valid && in_ready`: `mem[ptr]` := `in_data`, ptr += 1, `wr_count` += 1.
  - On the write with ptr = DEPTH-1: → FULL, `load_done` pulses the next cycle, and `wr_count` = DEPTH.
  - `start` while in LOAD is ignored; the load continues.
- FULL: `in_ready`=0, `loaded`=1. `start` → LOAD, ptr := 0, `wr_count` := 0, `loaded` := 0. Old contents remain until overwritten.
- The write pointer wraps only by leaving LOAD. No write ever occurs outside LOAD.
- Read port is always active in every state. `rd_data` := `mem[rd_addr]` registered, read-first: a same-cycle write to the same address returns the old value, and the new value appears one cycle later.
- Data is stored bit-exact: no sign extension, truncation or saturation.
- Reset (asynchronous, any state, including mid-load):
  - state := IDLE, ptr := 0, `wr_count` := 0.
  - All `mem` entries := 0.
  - `rd_data` := 0, `load_done` := 0, `loaded` := 0, `in_ready` := 0.

## Timing
- Write latency: a sample accepted at edge N is visible on `rd_data` at edge N+2 when `rd_addr` targets it from edge N+1 onward. The read itself has one-cycle latency.
- `in_ready` is a registered state decode. It rises the cycle after `start` is sampled and falls in the cycle after the final accepted write.
- `load_done` is high for exactly one cycle, coincident with the first FULL cycle. `loaded` rises in the same cycle.
- Full load minimum duration: DEPTH+1 cycles from `start` with `in_valid` held high.
- `in_valid` gaps stall the load indefinitely; no timeout.
- Simultaneous `start` and last write in LOAD: the write completes, → FULL; `start` is ignored.
- `rst` deassertion: the first active edge after release samples `start` normally.

## Test plan
- Reset values: assert `rst` mid-stream, then release → all outputs 0, state IDLE, and reading addresses 0..3 returns 0 on each.
- Basic load, DEPTH=4: pulse `start`, then stream 10, -3, 7, 1000 with `in_valid` held → `load_done` pulses exactly once, `wr_count`=4, and reading 0..3 returns 10, -3, 7, 1000 one cycle after each address.
- Backpressure and gaps: insert `in_valid` low for 3 cycles between samples → no extra writes, `wr_count` increments only on handshakes, and the final contents match the stream.
- Read-first collision: read address 1 while sample 42 is written to address 1 (old value -3) → `rd_data`=-3 next cycle, then 42 the cycle after.
- Restart and ignored start:
  - `start` during LOAD → ignored; the pointer keeps advancing.
  - `start` in FULL → `loaded` drops and `wr_count`=0. Load 5, 6, 7, 8 → address 0 reads 5 after the first write while addresses 1..3 still read the old values until overwritten.
- Reset mid-load: after 2 of 4 writes, pulse `rst` → entries 0..1 read 0, `in_ready`=0, and a subsequent `start` begins at address 0.
